// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state and LED encodings for the pong game controller
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LED_IDLE  = 4'b0000;
  localparam logic [3:0] LED_SERVE = 4'b0001;
  localparam logic [3:0] LED_PLAY  = 4'b0010;
  localparam logic [3:0] LED_POINT = 4'b0100;
  localparam logic [3:0] LED_OVER  = 4'b1000;

  // The OVER pattern carries the winner in bit 0 (1 = player B).
  function automatic logic [3:0] led_code(input state_t st, input logic b_won);
    case (st)
      ST_SERVE: return LED_SERVE;
      ST_PLAY:  return LED_PLAY;
      ST_POINT: return LED_POINT;
      ST_OVER:  return LED_OVER | {3'b000, b_won};
      default:  return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - frame pacing, miss reports and ball controls to the datapath
interface pong_game_ctrl_if;
  logic FRAME_TICK;
  logic MISS_A;
  logic MISS_B;
  logic BALL_RUN;
  logic BALL_INIT;
  logic SERVE_DIR;

  modport master (
    input  FRAME_TICK,
    input  MISS_A,
    input  MISS_B,
    output BALL_RUN,
    output BALL_INIT,
    output SERVE_DIR
  );

  modport slave (
    output FRAME_TICK,
    output MISS_A,
    output MISS_B,
    input  BALL_RUN,
    input  BALL_INIT,
    input  SERVE_DIR
  );
endinterface

// File: rtl/pong_btn_sync.sv
// rtl/pong_btn_sync.sv - button synchroniser with frame-rate debounce and press pulse
module pong_btn_sync (
  input  logic CLK,
  input  logic RST,
  input  logic FRAME_TICK,
  input  logic button,
  output logic press
);

  logic sync1;
  logic sync2;
  logic sample;

  // Sampling only on frame ticks filters bounce shorter than one frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sample <= 1'b1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (FRAME_TICK) begin
        sample <= sync2;
      end
    end
  end

  assign press = FRAME_TICK & sample & ~sync2;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - game-flow sequencer: serve, rally, point pause, game over
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned FCNT_W       = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Button_A,
  input  logic                  Button_B,
  pong_game_ctrl_if.master      game,
  output logic [SCORE_W-1:0]    SCORE_A,
  output logic [SCORE_W-1:0]    SCORE_B,
  output logic [2:0]            STATE,
  output logic [3:0]            LED
);

  localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_n;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_n;
  logic [SCORE_W-1:0] score_a_q, score_a_n;
  logic [SCORE_W-1:0] score_b_q, score_b_n;
  logic               ball_run_q, ball_run_n;
  logic               ball_init_q, ball_init_n;
  logic               serve_dir_q, serve_dir_n;
  logic [3:0]         led_q, led_n;

  logic press_a;
  logic press_b;
  logic tick;
  logic miss_a;
  logic miss_b;
  logic game_won;

  pong_btn_sync u_btn_a (
    .CLK        (CLK),
    .RST        (RST),
    .FRAME_TICK (game.FRAME_TICK),
    .button     (Button_A),
    .press      (press_a)
  );

  pong_btn_sync u_btn_b (
    .CLK        (CLK),
    .RST        (RST),
    .FRAME_TICK (game.FRAME_TICK),
    .button     (Button_B),
    .press      (press_b)
  );

  assign tick     = game.FRAME_TICK;
  assign miss_a   = game.MISS_A;
  assign miss_b   = game.MISS_B;
  assign game_won = (score_a_q == WIN) || (score_b_q == WIN);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      ball_run_q  <= 1'b0;
      ball_init_q <= 1'b0;
      serve_dir_q <= 1'b0;
      led_q       <= LED_IDLE;
    end else begin
      state_q     <= state_n;
      fcnt_q      <= fcnt_n;
      score_a_q   <= score_a_n;
      score_b_q   <= score_b_n;
      ball_run_q  <= ball_run_n;
      ball_init_q <= ball_init_n;
      serve_dir_q <= serve_dir_n;
      led_q       <= led_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (press_a || press_b) state_n = ST_SERVE;
      ST_SERVE: if (tick && fcnt_q == SERVE_LAST) state_n = ST_PLAY;
      ST_PLAY:  if (miss_a || miss_b) state_n = ST_POINT;
      ST_POINT: if (tick && fcnt_q == POINT_LAST) state_n = game_won ? ST_OVER : ST_SERVE;
      ST_OVER:  if (press_a || press_b) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    score_a_n   = score_a_q;
    score_b_n   = score_b_q;
    serve_dir_n = serve_dir_q;
    ball_init_n = 1'b0;

    // A tick landing on a transition edge belongs to the old state, so it is dropped.
    if (state_n != state_q) begin
      fcnt_n = '0;
    end else if (tick && (state_q == ST_SERVE || state_q == ST_POINT)) begin
      fcnt_n = fcnt_q + 1'b1;
    end else begin
      fcnt_n = fcnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (press_a || press_b) begin
          score_a_n   = '0;
          score_b_n   = '0;
          ball_init_n = 1'b1;
          serve_dir_n = press_a;
        end
      end
      ST_PLAY: begin
        if (miss_a && !miss_b) begin
          score_b_n   = score_b_q + 1'b1;
          serve_dir_n = 1'b0;
        end else if (miss_b && !miss_a) begin
          score_a_n   = score_a_q + 1'b1;
          serve_dir_n = 1'b1;
        end
      end
      ST_POINT: begin
        if (state_n == ST_SERVE) begin
          ball_init_n = 1'b1;
        end
      end
      default: ;
    endcase

    ball_run_n = (state_n == ST_PLAY);
    led_n      = led_code(state_n, score_b_n == WIN);
  end

  assign game.BALL_RUN  = ball_run_q;
  assign game.BALL_INIT = ball_init_q;
  assign game.SERVE_DIR = serve_dir_q;
  assign SCORE_A        = score_a_q;
  assign SCORE_B        = score_b_q;
  assign STATE          = state_q;
  assign LED            = led_q;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow controller for pong_main. It sequences the ball/paddle datapath through idle, serve, rally, point and game-over phases. It keeps both players' scores and drives ball run/re-centre controls and the status LEDs. It is clocked by the 75 MHz pixel clock and paced by a once-per-frame tick derived from the VESA sync generator.

Parameters:
WIN_SCORE, 5, score that ends the game; must be < 2**SCORE_W.
SCORE_W, 4, width of each score counter.
SERVE_FRAMES, 60, FRAME_TICKs spent in SERVE before ball release (>=1).
POINT_FRAMES, 30, FRAME_TICKs spent in POINT pause (>=1).
FCNT_W, 8, frame counter width; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
CLK  in  1  pixel clock, 75 MHz.
RST  in  1  reset; synchronous, active-low.
FRAME_TICK  in  1  one-cycle pulse per frame, first cycle of vertical blanking.
Button_A  in  1  player A button, asynchronous, active-low (idle 1).
Button_B  in  1  player B button, asynchronous, active-low (idle 1).
MISS_A  in  1  one-cycle pulse from the ball datapath when the ball passes A's (left) edge.
MISS_B  in  1  one-cycle pulse when the ball passes B's (right) edge.
BALL_RUN  out  1  high: ball datapath advances position each frame.
BALL_INIT  out  1  one-cycle pulse: datapath reloads the ball to screen centre.
SERVE_DIR  out  1  initial ball direction after BALL_INIT: 0 = toward A, 1 = toward B.
SCORE_A  out  SCORE_W  player A points.
SCORE_B  out  SCORE_W  player B points.
STATE  out  3  current state encoding, for debug and overlay.
LED  out  4  status LEDs.

Behaviour:
- All flops update on posedge CLK. When RST==0 at an edge, all outputs take their reset values: STATE=IDLE, SCORE_A/B=0, BALL_RUN=0, BALL_INIT=0, SERVE_DIR=0, LED=0000, frame counter=0, button sync flops=1. Reset mid-game abandons the game with no residual pulses.
- Buttons: each button passes through a 2-FF synchroniser, then is sampled only on FRAME_TICK (frame-rate debounce). A press event is a one-cycle pulse on the FRAME_TICK cycle where the sample goes 1 to 0. A held button gives exactly one event.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. All outputs are registered. A state change is visible on the cycle after the cause.
- IDLE: press A or B -> SERVE. On that transition: scores cleared, BALL_INIT pulse, SERVE_DIR=1 if A pressed, 0 if B. If both press on the same tick, A wins.
- SERVE: BALL_RUN=0. The frame counter increments on each FRAME_TICK. When the count reaches SERVE_FRAMES -> PLAY, and BALL_RUN=1 from the next cycle.
- PLAY: BALL_RUN=1.
  - MISS_A alone: SCORE_B+1, SERVE_DIR=0, -> POINT.
  - MISS_B alone: SCORE_A+1, SERVE_DIR=1, -> POINT.
  - MISS_A and MISS_B in the same cycle: no score change, SERVE_DIR unchanged, -> POINT.
  - BALL_RUN drops the cycle after the miss.
- MISS_A/MISS_B outside PLAY are ignored. Button events outside IDLE/OVER are ignored.
- POINT: BALL_RUN=0. Count POINT_FRAMES ticks, then:
  - if SCORE_A==WIN_SCORE or SCORE_B==WIN_SCORE -> OVER;
  - else -> SERVE with a BALL_INIT pulse on the transition.
- OVER: BALL_RUN=0 and scores are held. Any press event -> IDLE. Scores persist until the next game start.
- Frame counter: cleared on every state transition. A FRAME_TICK coinciding with the transition cycle is not counted.
- Scores never wrap. The game ends at WIN_SCORE, which is < 2**SCORE_W.
- BALL_INIT is high for exactly one cycle per serve and never in the same cycle that BALL_RUN is high.
- LED:
  - IDLE 0000, SERVE 0001, PLAY 0010, POINT 0100.
  - OVER = {1,0,0,winner}, where winner=1 if B won.

Decomposition:
- pong_pkg: state encoding constants (IDLE..OVER) and LED code constants.
- Sub-module pong_btn_sync: 2-FF synchroniser, FRAME_TICK sampling and falling-edge press pulse; same CLK/RST. Instantiated once per button.

Test Plan:
(Parameters for all scenarios: WIN_SCORE=2, SERVE_FRAMES=2, POINT_FRAMES=1.)
- Reset: RST=0 for 3 cycles with MISS_A pulsing -> STATE=0, scores 0, LED=0000, BALL_RUN=0, BALL_INIT never high.
- Start: Button_A low across 2 FRAME_TICKs.
  - Expect one BALL_INIT pulse, STATE=1 and SERVE_DIR=1 the cycle after the first tick.
  - After 2 more ticks: STATE=2, BALL_RUN=1.
  - Holding the button generates no further events.
- Point: in PLAY, pulse MISS_A.
  - Next cycle: SCORE_B=1, SERVE_DIR=0, STATE=3, BALL_RUN=0.
  - After 1 tick: BALL_INIT pulse, STATE=1.
- Simultaneous miss: MISS_A and MISS_B together in PLAY -> scores unchanged, SERVE_DIR unchanged, STATE=3.
- Game over: B scores twice -> after the POINT pause, STATE=4, LED=1001. Then Button_B press -> STATE=0 with scores still 0/2. Then Button_A press -> scores 0/0, STATE=1.
- Glitch/ignore:
  - Button toggling between FRAME_TICKs with no level change at the tick -> no event.
  - MISS_B pulse in SERVE -> no score change.
